mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, default 15, meaning the number of cycles without mem_ack in one byte transaction before an access aborts.
REQ-002 The block SHALL have these ports:
- clk  in  1  clock; all state changes on the rising edge
- global_reset  in  1  reset, asynchronous and active-high
- memRd  in  1  read request from the control path
- memWr  in  1  write request from the control path
- ctrl  in  1  access size: 1 = word, 0 = byte
- I  in  2  address select: 00 = pc, 01 = mdr, 10 = alu_out, 11 = 16'h0000
- ir_wr, mdr_l, mdr_h  in  1 each  load enables for the IR, MDR low byte and MDR high byte
- pc, alu_out, st_data  in  16 each  address sources and store data
- mem_rdata  in  8  byte read data from memory
- mem_ack  in  1  memory acknowledge
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  16  byte address
- mem_wdata  out  8  byte write data
- ir  out  16  instruction register
- mdr  out  16  memory data register
- busy  out  1  high whenever the FSM is not in IDLE
- done  out  1  one-cycle pulse when an access completes
- err  out  1  one-cycle pulse when an access aborts or a command is illegal

Function
REQ-003 The FSM SHALL have five states: IDLE, LO, HI, DONE, ERR.
REQ-004 The block SHALL sample commands only in IDLE.
- memRd xor memWr = 1: latch ctrl, I, ir_wr, mdr_l, mdr_h, st_data and the selected address, then go to LO.
- Strobes asserted outside IDLE: ignored.
REQ-005 memRd and memWr both high in IDLE SHALL be an illegal command: go to ERR, with no memory transaction.
REQ-006 The base address SHALL be the latched source value.
- Word access: bit 0 forced to 0.
- Byte access: address used unmodified.
REQ-007 In LO and HI, the memory outputs SHALL be driven as follows:
- mem_req = 1.
- mem_we = latched memWr.
- mem_addr = base (LO) or base|1 (HI).
- mem_wdata = st_data[7:0] (LO) or st_data[15:8] (HI).
- All four held stable until a rising edge samples mem_ack = 1.
REQ-008 Leaving LO or HI:
- LO with mem_ack: go to HI for a word access, DONE for a byte access.
- HI with mem_ack: go to DONE.
- mem_req stays high across the LO-to-HI transition.
REQ-009 On a read, the byte sampled with the acknowledging edge SHALL be captured into a 16-bit assembly register: LO fills [7:0], HI fills [15:8] (little-endian).
REQ-010 On the edge entering DONE for a read:
- ir loads the assembled word if ir_wr was latched.
- mdr[7:0] loads if mdr_l was latched.
- mdr[15:8] loads if mdr_h was latched; for a byte read, mdr[15:8] is left unchanged.
REQ-011 Writes SHALL leave ir and mdr unchanged.
REQ-012 In DONE the block SHALL assert done = 1 for exactly one cycle and return to IDLE on the next edge.
REQ-013 Timeout handling:
- A 4-bit wait counter clears on entry to LO or HI and increments each cycle without mem_ack.
- When it reaches TIMEOUT, the FSM goes to ERR.
- In ERR: err = 1 for one cycle, mem_req = 0, ir and mdr not updated, return to IDLE.
REQ-014 Latency with zero-wait memory (mem_ack already high), counted from the command edge: done SHALL be high in cycle 3 for a word access and in cycle 2 for a byte access.
REQ-015 In IDLE, DONE and ERR the outputs SHALL be mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
REQ-016 Base address 16'hFFFF on a word access SHALL access 16'hFFFE, then 16'hFFFF, with no wrap.

Reset
REQ-017 global_reset = 1 SHALL, asynchronously:
- force the FSM to IDLE;
- clear the wait counter and the assembly register;
- drive ir, mdr, mem_req, mem_we, mem_addr, mem_wdata, busy, done and err to 0.
REQ-018 A reset in LO or HI SHALL drop mem_req immediately, abandon the transaction and leave no partial update in ir or mdr.
REQ-019 After reset is released, the first rising edge SHALL be able to accept a command.

Verification
REQ-020 Word fetch: pc = 16'h3001, I = 00, memRd, ctrl = 1, ir_wr = 1; memory bytes 16'h3000 = 8'h34 and 16'h3001 = 8'h12, zero wait -> mem_addr 16'h3000 then 16'h3001, ir = 16'h1234, done in cycle 3.
REQ-021 Byte store: alu_out = 16'h0105, I = 10, memWr, ctrl = 0, st_data = 16'hABCD -> a single transaction with mem_addr 16'h0105, mem_wdata 8'hCD, mem_we 1; done in cycle 2.
REQ-022 Byte load: mdr = 16'h5500, mdr_l = 1, memory byte 8'h7F, mem_ack delayed 3 cycles -> mem_req and mem_addr stable through the wait; mdr = 16'h557F.
REQ-023 Timeout: word read with mem_ack held at 0 -> err pulses after 15 wait cycles, mem_req drops, mdr and ir unchanged, busy returns to 0.
REQ-024 Illegal command: memRd = memWr = 1 -> err pulse, no mem_req; a further memRd pulse while busy is ignored.
REQ-025 Reset mid-access: global_reset asserted while in HI -> mem_req = 0 and busy = 0 without waiting for a clock edge; ir = 0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Byte-serial memory access unit: word/byte loads and stores over an 8-bit bus.
// Assembles little-endian words into IR/MDR; aborts on ack timeout or bad command.
module mem_access_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        global_reset,
    input  logic        memRd,
    input  logic        memWr,
    input  logic        ctrl,
    input  logic [1:0]  I,
    input  logic        ir_wr,
    input  logic        mdr_l,
    input  logic        mdr_h,
    input  logic [15:0] pc,
    input  logic [15:0] alu_out,
    input  logic [15:0] st_data,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic [15:0] ir,
    output logic [15:0] mdr,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LO   = 3'd1;
    localparam logic [2:0] HI   = 3'd2;
    localparam logic [2:0] DONE = 3'd3;
    localparam logic [2:0] ERR  = 3'd4;

    localparam logic [3:0] TMAX = 4'(TIMEOUT - 1);

    logic [2:0]  state;
    logic [3:0]  wcnt;
    logic [15:0] asm_q;
    logic [15:0] addr_q;
    logic [15:0] wdat_q;
    logic        word_q;
    logic        wr_q;
    logic        irw_q;
    logic        ml_q;
    logic        mh_q;
    logic [15:0] sel_addr;
    logic [15:0] base;
    logic [15:0] rd_word;
    logic        in_xfer;
    logic        fin;

    // Address source select for a new command
    always_comb begin
        sel_addr = 16'h0000;
        case (I)
            2'b00:   sel_addr = pc;
            2'b01:   sel_addr = mdr;
            2'b10:   sel_addr = alu_out;
            default: sel_addr = 16'h0000;
        endcase
    end

    // Bus drive, status flags and the word seen on the final read beat
    always_comb begin
        base      = word_q ? {addr_q[15:1], 1'b0} : addr_q;
        in_xfer   = (state == LO) || (state == HI);
        mem_req   = in_xfer;
        mem_we    = in_xfer & wr_q;
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;
        if (state == LO) begin
            mem_addr  = base;
            mem_wdata = wdat_q[7:0];
        end else if (state == HI) begin
            mem_addr  = base | 16'h0001;
            mem_wdata = wdat_q[15:8];
        end
        busy    = (state != IDLE);
        done    = (state == DONE);
        err     = (state == ERR);
        rd_word = (state == HI) ? {mem_rdata, asm_q[7:0]}
                                : {asm_q[15:8], mem_rdata};
        fin     = mem_ack && !wr_q &&
                  ((state == HI) || ((state == LO) && !word_q));
    end

    // Access sequencer: command latch, beat progression, wait timeout
    always_ff @(posedge clk or posedge global_reset) begin
        if (global_reset) begin
            state  <= IDLE;
            wcnt   <= 4'd0;
            asm_q  <= 16'h0000;
            addr_q <= 16'h0000;
            wdat_q <= 16'h0000;
            word_q <= 1'b0;
            wr_q   <= 1'b0;
            irw_q  <= 1'b0;
            ml_q   <= 1'b0;
            mh_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (memRd && memWr) begin
                        state <= ERR;
                    end else if (memRd ^ memWr) begin
                        addr_q <= sel_addr;
                        wdat_q <= st_data;
                        word_q <= ctrl;
                        wr_q   <= memWr;
                        irw_q  <= ir_wr;
                        ml_q   <= mdr_l;
                        mh_q   <= mdr_h;
                        asm_q  <= 16'h0000;
                        wcnt   <= 4'd0;
                        state  <= LO;
                    end
                end
                LO: begin
                    if (mem_ack) begin
                        wcnt <= 4'd0;
                        if (!wr_q) asm_q[7:0] <= mem_rdata;
                        state <= word_q ? HI : DONE;
                    end else if (wcnt == TMAX) begin
                        state <= ERR;
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
                HI: begin
                    if (mem_ack) begin
                        wcnt <= 4'd0;
                        if (!wr_q) asm_q[15:8] <= mem_rdata;
                        state <= DONE;
                    end else if (wcnt == TMAX) begin
                        state <= ERR;
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Architectural register update on the edge that completes a read
    always_ff @(posedge clk or posedge global_reset) begin
        if (global_reset) begin
            ir  <= 16'h0000;
            mdr <= 16'h0000;
        end else if (fin) begin
            if (irw_q) ir <= rd_word;
            if (ml_q) mdr[7:0] <= rd_word[7:0];
            if (mh_q && word_q) mdr[15:8] <= rd_word[15:8];
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: fetch, store, load with wait states,
// timeout, illegal command and asynchronous reset mid-access.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        global_reset;
    logic        memRd, memWr, ctrl;
    logic [1:0]  I;
    logic        ir_wr, mdr_l, mdr_h;
    logic [15:0] pc, alu_out, st_data;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [15:0] ir, mdr;
    logic        busy, done, err;

    logic [7:0] memb [0:65535];
    int errors = 0;
    int checks = 0;

    mem_access_unit #(.TIMEOUT(15)) dut (
        .clk(clk), .global_reset(global_reset),
        .memRd(memRd), .memWr(memWr), .ctrl(ctrl), .I(I),
        .ir_wr(ir_wr), .mdr_l(mdr_l), .mdr_h(mdr_h),
        .pc(pc), .alu_out(alu_out), .st_data(st_data),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .ir(ir), .mdr(mdr),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    assign mem_rdata = memb[mem_addr];

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic rd, input logic wr, input logic c,
                       input logic [1:0] sel, input logic iw,
                       input logic ml, input logic mh);
        memRd = rd; memWr = wr; ctrl = c; I = sel;
        ir_wr = iw; mdr_l = ml; mdr_h = mh;
        cyc();
        memRd = 1'b0; memWr = 1'b0;
    endtask

    initial begin
        global_reset = 1'b1;
        memRd = 0; memWr = 0; ctrl = 0; I = 0;
        ir_wr = 0; mdr_l = 0; mdr_h = 0;
        pc = 0; alu_out = 0; st_data = 0; mem_ack = 1'b1;
        memb[16'h3000] = 8'h34; memb[16'h3001] = 8'h12;
        memb[16'h0000] = 8'h00; memb[16'h0001] = 8'h55;
        memb[16'h0200] = 8'h7F;
        memb[16'h0400] = 8'hEE; memb[16'h0401] = 8'hDD;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_req", mem_req, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk("rst_ir", ir, 16'h0000);
        chk("rst_mdr", mdr, 16'h0000);
        @(negedge clk);
        global_reset = 1'b0;
        cyc();

        // Word fetch from pc=3001 (aligned to 3000)
        pc = 16'h3001;
        cmd(1, 0, 1, 2'b00, 1, 0, 0);
        chk1("wf_c1_req", mem_req, 1'b1);
        chk("wf_c1_addr", mem_addr, 16'h3000);
        chk1("wf_c1_done", done, 1'b0);
        cyc();
        chk1("wf_c2_req", mem_req, 1'b1);
        chk("wf_c2_addr", mem_addr, 16'h3001);
        cyc();
        chk1("wf_c3_done", done, 1'b1);
        chk1("wf_c3_req", mem_req, 1'b0);
        chk("wf_ir", ir, 16'h1234);
        cyc();
        chk1("wf_c4_done", done, 1'b0);
        chk1("wf_c4_busy", busy, 1'b0);

        // Byte store
        alu_out = 16'h0105; st_data = 16'hABCD;
        cmd(0, 1, 0, 2'b10, 0, 0, 0);
        chk("bs_addr", mem_addr, 16'h0105);
        chk("bs_wdata", {8'h00, mem_wdata}, 16'h00CD);
        chk1("bs_we", mem_we, 1'b1);
        cyc();
        chk1("bs_done", done, 1'b1);
        chk1("bs_req", mem_req, 1'b0);
        chk("bs_ir", ir, 16'h1234);
        chk("bs_mdr", mdr, 16'h0000);
        cyc();

        // Word read from 0000 to preload mdr = 5500
        cmd(1, 0, 1, 2'b11, 0, 1, 1);
        cyc();
        cyc();
        chk("pre_mdr", mdr, 16'h5500);
        cyc();

        // Byte load with ack delayed 3 cycles
        mem_ack = 1'b0; alu_out = 16'h0200;
        cmd(1, 0, 0, 2'b10, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            chk1("bl_wait_req", mem_req, 1'b1);
            chk("bl_wait_addr", mem_addr, 16'h0200);
            if (i < 2) cyc();
        end
        mem_ack = 1'b1;
        cyc();
        chk1("bl_done", done, 1'b1);
        chk("bl_mdr", mdr, 16'h557F);
        cyc();

        // Timeout on a word read
        mem_ack = 1'b0; pc = 16'h0400;
        cmd(1, 0, 1, 2'b00, 1, 1, 1);
        for (int i = 1; i <= 15; i++) begin
            chk1("to_wait_req", mem_req, 1'b1);
            chk1("to_wait_err", err, 1'b0);
            cyc();
        end
        chk1("to_err", err, 1'b1);
        chk1("to_req", mem_req, 1'b0);
        chk("to_mdr", mdr, 16'h557F);
        chk("to_ir", ir, 16'h1234);
        cyc();
        chk1("to_busy", busy, 1'b0);
        chk1("to_err_end", err, 1'b0);
        mem_ack = 1'b1;

        // Illegal command, then a read strobe while busy
        cmd(1, 1, 1, 2'b00, 1, 0, 0);
        chk1("il_err", err, 1'b1);
        chk1("il_req", mem_req, 1'b0);
        memRd = 1'b1;
        cyc();
        memRd = 1'b0;
        chk1("il_busy", busy, 1'b0);
        chk1("il_req2", mem_req, 1'b0);
        chk("il_ir", ir, 16'h1234);

        // Reset while in HI
        pc = 16'h3000;
        cmd(1, 0, 1, 2'b00, 1, 0, 0);
        cyc();
        chk1("rm_in_hi", mem_req, 1'b1);
        global_reset = 1'b1;
        #1;
        chk1("rm_req", mem_req, 1'b0);
        chk1("rm_busy", busy, 1'b0);
        chk("rm_ir", ir, 16'h0000);
        chk("rm_mdr", mdr, 16'h0000);
        @(negedge clk);
        global_reset = 1'b0;

        // First edge after reset accepts a byte load
        alu_out = 16'h0200;
        cmd(1, 0, 0, 2'b10, 0, 1, 0);
        chk1("ar_req", mem_req, 1'b1);
        cyc();
        chk1("ar_done", done, 1'b1);
        chk("ar_mdr", mdr, 16'h007F);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
